// File: rtl/axis_loop_sched.sv
// axis_loop_sched: periodic ADC -> PID -> DAC control-loop sequencer.
//
// Each period tick starts one sequence. The sequence requests the ADC
// conversions and waits for them, with a timeout. It then runs the shared PID
// unit for X and loads the X DAC, and after that does the same for Y.
//
// Build option: define SCHED_Y_AXIS_EN to sequence the Y axis as well. When it
// is undefined, only the X axis is handled. In that build y_adc_start,
// y_dac_load and pid_sel stay at 0.
//
// Ports:
//   clk_in                   system clock (about 82 MHz)
//   cnt_rstn                 asynchronous active-low reset
//   enable                   loop runs while high
//   err_clr                  pulse; clears overrun, adc_tmo and err_cnt
//   x/y_adc_start            conversion request pulses
//   x/y_adc_valid            conversion done pulses
//   pid_start, pid_sel       PID request pulse and served axis (0 = X, 1 = Y)
//   pid_done                 PID result ready pulse
//   x/y_dac_ready            DAC interface idle
//   x/y_dac_load             DAC update pulses
//   overrun                  sticky: tick arrived while a sequence was active
//   adc_tmo                  sticky: ADC conversion timed out
//   err_cnt                  saturating count of overruns plus timeouts
//   busy                     a sequence is in progress
module axis_loop_sched #(
    parameter int PERIOD_CYC = 273,
    parameter int ADC_TMO    = 200,
    parameter int ERR_W      = 8
) (
    input  logic             clk_in,
    input  logic             cnt_rstn,
    input  logic             enable,
    input  logic             err_clr,
    output logic             x_adc_start,
    output logic             y_adc_start,
    input  logic             x_adc_valid,
    input  logic             y_adc_valid,
    output logic             pid_start,
    output logic             pid_sel,
    input  logic             pid_done,
    input  logic             x_dac_ready,
    input  logic             y_dac_ready,
    output logic             x_dac_load,
    output logic             y_dac_load,
    output logic             overrun,
    output logic             adc_tmo,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);
    localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TW = $clog2(ADC_TMO + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    // The counter is loaded in CONV and reaches 0 in the ADC_TMO-th cycle after
    // adc_start. A valid pulse that arrives in that cycle is still accepted.
    localparam logic [TW-1:0] TMO_LOAD = TW'(ADC_TMO - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_TICK, CONV, WAIT_ADC, PID_X, WAIT_PX, DAC_X, PID_Y, WAIT_PY, DAC_Y
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   per_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            tick, x_lat, x_ok, y_ok, adc_done, ovr_ev, tmo_ev;
    logic [ERR_W:0]  err_sum;

`ifdef SCHED_Y_AXIS_EN
    localparam bit Y_EN = 1'b1;
    logic y_lat;

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)
            y_lat <= 1'b0;
        else if (state == CONV)
            y_lat <= 1'b0;
        else if (state == WAIT_ADC && y_adc_valid)
            y_lat <= 1'b1;
    end

    assign y_ok = y_lat | y_adc_valid;
`else
    localparam bit Y_EN = 1'b0;
    logic unused_y;

    assign unused_y = y_adc_valid;
    assign y_ok     = 1'b1;
`endif

    // Free-running period counter. It is held at 0 while the loop is disabled.
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)
            per_cnt <= '0;
        else if (!enable || per_cnt == PER_LAST)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    assign tick = enable && per_cnt == PER_LAST;

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)
            tmo_cnt <= '0;
        else if (state == CONV)
            tmo_cnt <= TMO_LOAD;
        else if (state == WAIT_ADC && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
    end

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)
            x_lat <= 1'b0;
        else if (state == CONV)
            x_lat <= 1'b0;
        else if (state == WAIT_ADC && x_adc_valid)
            x_lat <= 1'b1;
    end

    // A pulse arriving in the same cycle counts toward completing the pair.
    assign x_ok     = x_lat | x_adc_valid;
    assign adc_done = x_ok & y_ok;
    assign tmo_ev   = state == WAIT_ADC && !adc_done && tmo_cnt == '0;
    // A tick outside WAIT_TICK is dropped, not queued. The drop is only recorded.
    assign ovr_ev   = tick && state != WAIT_TICK;

    // Both events can occur in the same cycle, so both are added. The carry
    // bit of the sum shows that the counter has saturated.
    assign err_sum = {1'b0, err_cnt} + (ERR_W+1)'(ovr_ev) + (ERR_W+1)'(tmo_ev);

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            overrun <= 1'b0;
            adc_tmo <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            overrun <= 1'b0;
            adc_tmo <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (ovr_ev)
                overrun <= 1'b1;
            if (tmo_ev)
                adc_tmo <= 1'b1;
            err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (enable) state_n = WAIT_TICK;
            WAIT_TICK: state_n = tick ? CONV : (!enable ? IDLE : WAIT_TICK);
            CONV:      state_n = WAIT_ADC;
            WAIT_ADC:  state_n = adc_done ? PID_X : (tmo_cnt == '0 ? WAIT_TICK : WAIT_ADC);
            PID_X:     state_n = WAIT_PX;
            WAIT_PX:   if (pid_done) state_n = DAC_X;
            DAC_X:     if (x_dac_ready) state_n = Y_EN ? PID_Y : WAIT_TICK;
            PID_Y:     state_n = WAIT_PY;
            WAIT_PY:   if (pid_done) state_n = DAC_Y;
            DAC_Y:     if (y_dac_ready) state_n = WAIT_TICK;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        x_adc_start = state == CONV;
        y_adc_start = Y_EN && state == CONV;
        pid_start   = state == PID_X || state == PID_Y;
        pid_sel     = Y_EN && (state == PID_Y || state == WAIT_PY);
        x_dac_load  = state == DAC_X && x_dac_ready;
        y_dac_load  = Y_EN && state == DAC_Y && y_dac_ready;
        busy        = state != IDLE && state != WAIT_TICK;
    end
endmodule

// File: doc/axis_loop_sched.md
AXIS_LOOP_SCHED -- requirements
Module: axis_loop_sched

Interface
REQ-001 Parameter PERIOD_CYC, default 273, sets the control-loop period in clk_in cycles (about 300 kHz).
REQ-002 Parameter ADC_TMO, default 200, sets the maximum number of cycles from adc_start to the last required adc valid.
REQ-003 Parameter ERR_W, default 8, sets the width of the saturating error counter.
REQ-004 clk_in  input  1  system clock, internal oscillator, about 82 MHz.
REQ-005 cnt_rstn  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  level; loop runs while high.
REQ-007 err_clr  input  1  single-cycle pulse; clears sticky flags and err_cnt.
REQ-008 x_adc_start, y_adc_start  output  1 each  single-cycle conversion request pulse.
REQ-009 x_adc_valid, y_adc_valid  input  1 each  single-cycle conversion-done pulse.
REQ-010 pid_start  output  1  single-cycle request to the shared PID unit.
REQ-011 pid_sel  output  1  axis served by the PID: 0 = X, 1 = Y; stable from pid_start until pid_done.
REQ-012 pid_done  input  1  single-cycle PID result-ready pulse.
REQ-013 x_dac_ready, y_dac_ready  input  1 each  DAC interface idle.
REQ-014 x_dac_load, y_dac_load  output  1 each  single-cycle DAC update pulse.
REQ-015 overrun  output  1  sticky: a tick arrived while a sequence was active.
REQ-016 adc_tmo  output  1  sticky: ADC timeout occurred.
REQ-017 err_cnt  output  ERR_W  saturating count of overruns plus timeouts.
REQ-018 busy  output  1  high in every state except IDLE and WAIT_TICK.

Function
REQ-019 The period counter shall count 0..PERIOD_CYC-1 while enable=1, shall wrap to 0, shall assert tick in the cycle it equals PERIOD_CYC-1, and shall be held at 0 while enable=0.
REQ-020 The FSM states shall be IDLE, WAIT_TICK, CONV, WAIT_ADC, PID_X, WAIT_PX, DAC_X, PID_Y, WAIT_PY, DAC_Y.
REQ-021 In IDLE, enable=1 shall move the FSM to WAIT_TICK.
REQ-022 In WAIT_TICK, tick shall move the FSM to CONV; enable=0 shall move it to IDLE.
REQ-023 CONV shall pulse x_adc_start and y_adc_start in the cycle after the tick, clear the valid latches, load the timeout counter, and go to WAIT_ADC.
REQ-024 In WAIT_ADC, each valid pulse shall set its own latch; simultaneous pulses shall be legal.
REQ-025 When both latches are set, or the incoming pulse completes the pair, the FSM shall go to PID_X.
REQ-026 If ADC_TMO cycles elapse in WAIT_ADC without both latches set, the block shall set adc_tmo, increment err_cnt, skip the DAC updates and return to WAIT_TICK.
REQ-027 PID_X shall pulse pid_start with pid_sel=0; WAIT_PX shall wait for pid_done and then go to DAC_X.
REQ-028 DAC_X shall hold until x_dac_ready=1, then pulse x_dac_load and go to PID_Y.
REQ-029 PID_Y, WAIT_PY and DAC_Y shall repeat REQ-027 and REQ-028 with pid_sel=1 and the Y signals; DAC_Y shall exit to WAIT_TICK.
REQ-030 A tick outside WAIT_TICK shall set overrun and increment err_cnt; the tick shall be dropped, not queued.
REQ-031 Valid pulses outside WAIT_ADC and pid_done outside WAIT_PX/WAIT_PY shall be ignored.
REQ-032 err_cnt shall saturate at all-ones; if err_clr and an error event occur in the same cycle, err_clr wins.
REQ-033 If enable falls mid-sequence, the current sequence shall complete, and the FSM shall then go from WAIT_TICK to IDLE.

Reset
REQ-034 While cnt_rstn=0, every output shall be 0, the FSM shall be in IDLE, and all counters and latches shall be 0.
REQ-035 Reset asserted mid-sequence shall abort the sequence immediately with no further pulses.

Configuration
REQ-036 With macro SCHED_Y_AXIS_EN defined, both axes shall be sequenced as specified above.
REQ-037 With SCHED_Y_AXIS_EN undefined, y_adc_start and y_dac_load shall be held at 0, pid_sel shall be held at 0, WAIT_ADC shall require only the X latch, and DAC_X shall exit to WAIT_TICK.

Verification
REQ-038 Normal cycle: enable=1, ADC valid pulses after 40 cycles, pid_done after 10 cycles, DAC ready -> exactly one of each pulse per 273 cycles, X handled before Y, no errors.
REQ-039 ADC timeout: x_adc_valid only, with Y never responding -> adc_tmo=1 and err_cnt=1 at cycle 200 after start, no DAC pulses, next period runs normally.
REQ-040 Overrun: pid_done withheld for 300 cycles -> overrun=1 and err_cnt=1, the sequence then completes and the next tick is honoured.
REQ-041 Saturation and clear: force 260 errors -> err_cnt=255; err_clr pulsed coincident with an error event -> flags=0 and err_cnt=0.
REQ-042 enable dropped during WAIT_PY -> DAC_Y still pulses, then IDLE, with no adc_start afterwards.
REQ-043 Reset pulsed during DAC_X with x_dac_ready=0 -> all outputs 0 and no x_dac_load pulse after release.
